// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the SPI transfer arbiter.
package spi_arb_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, LOAD, SHIFT, HOLD} arb_state_e;

  localparam int SPI_BYTE_W = 8;
  localparam int MAX_REQ    = 8;

  // Round-robin pick: first set request at or after ptr, wrapping at n.
  // Returns ptr unchanged when nothing is requesting (caller gates on any-request).
  function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] reqs,
                                          input int unsigned ptr,
                                          input int unsigned n);
    int unsigned pick;
    int unsigned idx;
    logic        found;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      idx = (ptr + i) % n;
      if (!found && (i < n) && (|(reqs & (MAX_REQ'(1) << idx)))) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/spi_byte_engine.sv
// Mode-3 (CPOL=1, CPHA=1) MSB-first byte shifter.
// SCLK idles high; the first falling edge follows start by one clk and
// presents bit 7, later falling edges present the next bit, MISO is sampled
// on every rising edge. done pulses on the clk after the eighth rising edge.
module spi_byte_engine
  import spi_arb_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SPI_BYTE_W-1:0] tx_byte,
  input  logic                  miso,
  output logic                  done,
  output logic [SPI_BYTE_W-1:0] rx_byte,
  output logic                  sclk,
  output logic                  mosi
);

  localparam int DIV_W = $clog2(CLK_DIV);

  logic                  active;
  logic [DIV_W-1:0]      div_cnt;
  logic [2:0]            bit_cnt;
  logic [SPI_BYTE_W-2:0] tx_rest;
  logic [SPI_BYTE_W-2:0] rx_sh;

  // Half-period down-counter drives alternating falling/rising SCLK edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_rest <= '0;
      rx_sh   <= '0;
      rx_byte <= '0;
      done    <= 1'b0;
      sclk    <= 1'b1;
      mosi    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!active) begin
        if (start) begin
          active  <= 1'b1;
          tx_rest <= tx_byte[SPI_BYTE_W-2:0];
          mosi    <= tx_byte[SPI_BYTE_W-1];
          sclk    <= 1'b0;
          div_cnt <= DIV_W'(CLK_DIV - 1);
          bit_cnt <= '0;
        end
      end else if (div_cnt != '0) begin
        div_cnt <= div_cnt - 1'b1;
      end else begin
        div_cnt <= DIV_W'(CLK_DIV - 1);
        if (!sclk) begin
          sclk  <= 1'b1;
          rx_sh <= {rx_sh[SPI_BYTE_W-3:0], miso};
          if (bit_cnt == 3'd7) begin
            active  <= 1'b0;
            done    <= 1'b1;
            rx_byte <= {rx_sh, miso};
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end else begin
          sclk    <= 1'b0;
          mosi    <= tx_rest[SPI_BYTE_W-2];
          tx_rest <= {tx_rest[SPI_BYTE_W-3:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Shares one SPI mode-3 master among N_REQ requesters, one multi-byte burst
// per grant, with a dedicated active-low chip select per requester.
// Build option: SPI_ARB_FIXED_PRIO_EN selects fixed priority (lowest index
// wins) instead of the default round-robin arbitration.
//
//   state | meaning
//   IDLE  | CS all high, waiting for any req_valid
//   SETUP | owner CS low, counting CS setup time
//   LOAD  | waiting for owner tx_valid; SCLK parked high
//   SHIFT | byte engine running
//   HOLD  | last byte done, counting CS hold time
//
// req_ready/tx_ready are registered: the request (and req_len) or the TX byte
// is captured on the edge that raises the pulse, so the client advances
// when it sees the pulse.
module spi_xfer_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int LEN_W    = 4,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*LEN_W-1:0]      req_len,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*SPI_BYTE_W-1:0] tx_data,
  input  logic [N_REQ-1:0]            tx_valid,
  output logic [N_REQ-1:0]            tx_ready,
  output logic [SPI_BYTE_W-1:0]       rx_data,
  output logic                        rx_valid,
  output logic [$clog2(N_REQ)-1:0]    rx_id,
  output logic                        rx_last,
  output logic                        busy,
  output logic                        SPI_CLK,
  output logic                        SPI_MOSI,
  input  logic                        SPI_MISO,
  output logic [N_REQ-1:0]            SPI_CS_N
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int T_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int T_W   = $clog2(T_MAX + 1);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  arb_state_e            state;
  logic [ID_W-1:0]       owner;
  logic [ID_W-1:0]       win;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      byte_cnt;
  logic [T_W-1:0]        tmr;
  logic [SPI_BYTE_W-1:0] tx_q;
  logic                  eng_start;
  logic                  eng_done;
  logic [SPI_BYTE_W-1:0] eng_rx;
  int unsigned           pick;
`ifndef SPI_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]       rr_ptr;
`endif

  // Arbitration winner among the current requests.
  always_comb begin
`ifdef SPI_ARB_FIXED_PRIO_EN
    pick = rr_pick(MAX_REQ'(req_valid), 0, N_REQ);
`else
    pick = rr_pick(MAX_REQ'(req_valid), 32'(rr_ptr), N_REQ);
`endif
    win = ID_W'(pick);
  end

  // Burst sequencing FSM with registered handshake, CS and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= '0;
      len_q     <= '0;
      byte_cnt  <= '0;
      tmr       <= '0;
      tx_q      <= '0;
      eng_start <= 1'b0;
      req_ready <= '0;
      tx_ready  <= '0;
      rx_valid  <= 1'b0;
      rx_last   <= 1'b0;
      rx_data   <= '0;
      rx_id     <= '0;
      busy      <= 1'b0;
      SPI_CS_N  <= '1;
`ifndef SPI_ARB_FIXED_PRIO_EN
      rr_ptr    <= '0;
`endif
    end else begin
      eng_start <= 1'b0;
      req_ready <= '0;
      tx_ready  <= '0;
      rx_valid  <= 1'b0;
      rx_last   <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            req_ready <= ONE << win;
            SPI_CS_N  <= ~(ONE << win);
            owner     <= win;
            len_q     <= req_len[win*LEN_W +: LEN_W];
            byte_cnt  <= '0;
            busy      <= 1'b1;
            tmr       <= T_W'(CS_SETUP - 1);
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (tmr == '0) state <= LOAD;
          else           tmr   <= tmr - 1'b1;
        end
        LOAD: begin
          if (tx_valid[owner]) begin
            tx_ready  <= ONE << owner;
            tx_q      <= tx_data[owner*SPI_BYTE_W +: SPI_BYTE_W];
            eng_start <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (eng_done) begin
            rx_valid <= 1'b1;
            rx_data  <= eng_rx;
            rx_id    <= owner;
            if (byte_cnt == len_q) begin
              rx_last <= 1'b1;
              tmr     <= T_W'(CS_HOLD - 1);
              state   <= HOLD;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
              state    <= LOAD;
            end
          end
        end
        HOLD: begin
          if (tmr == '0) begin
            SPI_CS_N <= '1;
            busy     <= 1'b0;
`ifndef SPI_ARB_FIXED_PRIO_EN
            rr_ptr   <= (owner == ID_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
`endif
            state    <= IDLE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  spi_byte_engine #(
    .CLK_DIV (CLK_DIV)
  ) u_engine (
    .clk     (clk),
    .rst     (rst),
    .start   (eng_start),
    .tx_byte (tx_q),
    .miso    (SPI_MISO),
    .done    (eng_done),
    .rx_byte (eng_rx),
    .sclk    (SPI_CLK),
    .mosi    (SPI_MOSI)
  );

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench for spi_xfer_arbiter with default parameters
// (N_REQ=2, LEN_W=4, CLK_DIV=4, CS_SETUP=2, CS_HOLD=2) and a mode-3 slave model.
module tb_spi_xfer_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [7:0]  req_len;
  logic [1:0]  req_ready;
  logic [15:0] tx_data;
  logic [1:0]  tx_valid;
  logic [1:0]  tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [0:0]  rx_id;
  logic        rx_last;
  logic        busy;
  logic        SPI_CLK;
  logic        SPI_MOSI;
  logic        SPI_MISO = 1'b0;
  logic [1:0]  SPI_CS_N;

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] tx_bytes [16];
  logic [7:0] slv_q [$];
  logic [7:0] slv_cur = 8'h00;
  int         slv_bit = 0;
  logic [7:0] mosi_cap = 8'h00;
  int         sclk_rises = 0;
  int         cs1_rises = 0;
  int         cs_multi = 0;
  int         txr_cnt [2];
  int         rr_pulses = 0;
  logic [1:0] cs_at_txr = 2'b11;
  logic [7:0] rx_d [$];
  int         rx_i [$];
  logic       rx_l [$];

  always #5 clk = ~clk;

  spi_xfer_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_len   (req_len),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_id     (rx_id),
    .rx_last   (rx_last),
    .busy      (busy),
    .SPI_CLK   (SPI_CLK),
    .SPI_MOSI  (SPI_MOSI),
    .SPI_MISO  (SPI_MISO),
    .SPI_CS_N  (SPI_CS_N)
  );

  // Mode-3 slave: new MISO bit on each falling edge, MSB first.
  always @(negedge SPI_CLK) begin
    if (slv_bit == 0) begin
      if (slv_q.size() > 0) slv_cur = slv_q.pop_front();
      else                  slv_cur = 8'h00;
    end
    SPI_MISO = slv_cur[7];
    slv_cur  = {slv_cur[6:0], 1'b0};
    slv_bit  = (slv_bit + 1) % 8;
  end

  always @(posedge SPI_CLK) begin
    mosi_cap = {mosi_cap[6:0], SPI_MOSI};
    sclk_rises++;
  end

  always @(posedge SPI_CS_N[1]) cs1_rises++;

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_d.push_back(rx_data);
      rx_i.push_back(int'(rx_id));
      rx_l.push_back(rx_last);
    end
    for (int i = 0; i < 2; i++) if (tx_ready[i]) txr_cnt[i]++;
    if (|tx_ready) cs_at_txr = SPI_CS_N;
    rr_pulses += $countones(req_ready);
    if ($countones(~SPI_CS_N) > 1) cs_multi++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_logs();
    rx_d.delete(); rx_i.delete(); rx_l.delete();
    txr_cnt[0] = 0; txr_cnt[1] = 0;
    sclk_rises = 0; cs1_rises = 0; rr_pulses = 0;
    cs_at_txr = 2'b11;
  endtask

  // Runs one burst for requester id; optional idle gap before byte gap_idx.
  task automatic do_burst(input int id, input int len, input int gap_idx,
                          input int gap_cyc, output int gap_bad);
    int t;
    gap_bad = 0;
    req_len[id*4 +: 4] = 4'(len);
    req_valid[id] = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!req_ready[id] && t < 100);
    req_valid[id] = 1'b0;
    n_vec++;
    if (!req_ready[id]) begin
      n_miss++;
      $display("FAIL grant_wait id=%0d: req_ready=%b, required bit %0d set", id, req_ready, id);
    end
    for (int b = 0; b <= len; b++) begin
      if (b == gap_idx) begin
        t = 0;
        do begin @(negedge clk); t++; end while (!rx_valid && t < 200);
        for (int g = 0; g < gap_cyc; g++) begin
          @(negedge clk);
          if (tx_ready[id] || SPI_CLK !== 1'b1 || SPI_CS_N[id] !== 1'b0) gap_bad++;
        end
      end
      tx_data[id*8 +: 8] = tx_bytes[b];
      tx_valid[id] = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!tx_ready[id] && t < 200);
      tx_valid[id] = 1'b0;
      n_vec++;
      if (!tx_ready[id]) begin
        n_miss++;
        $display("FAIL tx_wait id=%0d byte=%0d: tx_ready=%b, required pulse", id, b, tx_ready);
      end
    end
    t = 0;
    do begin @(negedge clk); t++; end while (busy && t < 300);
    n_vec++;
    if (busy !== 1'b0) begin
      n_miss++;
      $display("FAIL busy_wait id=%0d: busy=%b, required 0", id, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0; req_len = '0; tx_data = '0; tx_valid = '0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({SPI_CLK, SPI_MOSI, SPI_CS_N} !== 4'b1011) begin
      n_miss++;
      $display("FAIL reset_pins: clk/mosi/cs_n=%b, required 1011", {SPI_CLK, SPI_MOSI, SPI_CS_N});
    end
    n_vec++;
    if ({req_ready, tx_ready, rx_valid, rx_last, busy} !== 7'b0) begin
      n_miss++;
      $display("FAIL reset_pulses: %b, required 0000000", {req_ready, tx_ready, rx_valid, rx_last, busy});
    end
    n_vec++;
    if ({rx_data, rx_id} !== 9'h000) begin
      n_miss++;
      $display("FAIL reset_rx: rx_data=%h rx_id=%b, required 00/0", rx_data, rx_id);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_byte();
    int gb;
    clear_logs();
    slv_q.push_back(8'h3C);
    tx_bytes[0] = 8'hA5;
    do_burst(0, 0, -1, 0, gb);
    n_vec++;
    if (mosi_cap !== 8'hA5) begin n_miss++; $display("FAIL t1_mosi: %h, required a5", mosi_cap); end
    n_vec++;
    if (sclk_rises != 8) begin n_miss++; $display("FAIL t1_sclk_rises: %0d, required 8", sclk_rises); end
    n_vec++;
    if (cs_at_txr !== 2'b10) begin n_miss++; $display("FAIL t1_cs_burst: %b, required 10", cs_at_txr); end
    n_vec++;
    if (SPI_CS_N !== 2'b11) begin n_miss++; $display("FAIL t1_cs_end: %b, required 11", SPI_CS_N); end
    n_vec++;
    if (rx_d.size() != 1) begin
      n_miss++; $display("FAIL t1_rx_count: %0d, required 1", rx_d.size());
    end else if (rx_d[0] !== 8'h3C || rx_i[0] != 0 || rx_l[0] !== 1'b1) begin
      n_miss++; $display("FAIL t1_rx: data=%h id=%0d last=%b, required 3c/0/1", rx_d[0], rx_i[0], rx_l[0]);
    end
  endtask

  task automatic test_multi_byte();
    int gb;
    logic [7:0] exp_rx [3];
    exp_rx[0] = 8'h81; exp_rx[1] = 8'h42; exp_rx[2] = 8'hFF;
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      slv_q.push_back(exp_rx[i]);
      tx_bytes[i] = 8'(i + 1);
    end
    do_burst(1, 2, -1, 0, gb);
    n_vec++;
    if (txr_cnt[1] != 3 || txr_cnt[0] != 0) begin
      n_miss++; $display("FAIL t2_tx_ready: id1=%0d id0=%0d, required 3/0", txr_cnt[1], txr_cnt[0]);
    end
    n_vec++;
    if (sclk_rises != 24) begin n_miss++; $display("FAIL t2_sclk_rises: %0d, required 24", sclk_rises); end
    n_vec++;
    if (cs1_rises != 1 || cs_at_txr !== 2'b01) begin
      n_miss++; $display("FAIL t2_cs: rises=%0d cs_at_tx=%b, required 1/01", cs1_rises, cs_at_txr);
    end
    n_vec++;
    if (rx_d.size() != 3) begin
      n_miss++; $display("FAIL t2_rx_count: %0d, required 3", rx_d.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (rx_d[i] !== exp_rx[i] || rx_i[i] != 1 || rx_l[i] !== (i == 2)) begin
          n_miss++;
          $display("FAIL t2_rx%0d: data=%h id=%0d last=%b, required %h/1/%0d", i, rx_d[i], rx_i[i], rx_l[i], exp_rx[i], (i == 2));
        end
      end
    end
  endtask

  task automatic test_arbitration();
    int exp_win [4];
    int t;
    int id;
`ifdef SPI_ARB_FIXED_PRIO_EN
    exp_win = '{0, 0, 0, 0};
`else
    exp_win = '{0, 1, 0, 1};
`endif
    clear_logs();
    req_len = 8'h00;
    req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      t = 0;
      do begin @(negedge clk); t++; end while (req_ready == 2'b00 && t < 100);
      n_vec++;
      if (req_ready !== (2'b01 << exp_win[g])) begin
        n_miss++; $display("FAIL t3_grant%0d: req_ready=%b, required %b", g, req_ready, 2'b01 << exp_win[g]);
      end
      id = req_ready[1] ? 1 : 0;
      tx_data[id*8 +: 8] = 8'(8'h30 + g);
      tx_valid[id] = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!tx_ready[id] && t < 200);
      tx_valid[id] = 1'b0;
      t = 0;
      do begin @(negedge clk); t++; end while (busy && t < 300);
      if (g == 3) req_valid = 2'b00;
    end
    n_vec++;
    if (rr_pulses != 4) begin n_miss++; $display("FAIL t3_grant_total: %0d, required 4", rr_pulses); end
  endtask

  task automatic test_tx_gap();
    int gb;
    clear_logs();
    slv_q.push_back(8'h96); slv_q.push_back(8'h0F);
    tx_bytes[0] = 8'h11; tx_bytes[1] = 8'h22;
    do_burst(0, 1, 1, 20, gb);
    n_vec++;
    if (gb != 0) begin n_miss++; $display("FAIL t4_gap: bad cycles=%0d, required 0", gb); end
    n_vec++;
    if (txr_cnt[0] != 2) begin n_miss++; $display("FAIL t4_tx_ready: %0d, required 2", txr_cnt[0]); end
    n_vec++;
    if (rx_d.size() != 2) begin
      n_miss++; $display("FAIL t4_rx_count: %0d, required 2", rx_d.size());
    end else if (rx_d[0] !== 8'h96 || rx_d[1] !== 8'h0F || rx_l[0] !== 1'b0 || rx_l[1] !== 1'b1) begin
      n_miss++; $display("FAIL t4_rx: %h/%b %h/%b, required 96/0 0f/1", rx_d[0], rx_l[0], rx_d[1], rx_l[1]);
    end
  endtask

  task automatic test_reset_mid_burst();
    int t;
    int gb;
    int rx_snap;
    clear_logs();
    slv_q.push_back(8'hAA);
    req_len[3:0] = 4'd0;
    req_valid[0] = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!req_ready[0] && t < 100);
    req_valid[0] = 1'b0;
    tx_data[7:0] = 8'hF0;
    tx_valid[0] = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!tx_ready[0] && t < 200);
    tx_valid[0] = 1'b0;
    t = 0;
    while (sclk_rises < 4 && t < 200) begin @(negedge clk); t++; end
    n_vec++;
    if (sclk_rises != 4) begin n_miss++; $display("FAIL t5_reach_bit4: rises=%0d, required 4", sclk_rises); end
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({SPI_CS_N, SPI_CLK, busy, rx_valid} !== 5'b11100) begin
      n_miss++; $display("FAIL t5_after_rst: cs_n/sclk/busy/rx_valid=%b, required 11100", {SPI_CS_N, SPI_CLK, busy, rx_valid});
    end
    rst = 1'b0;
    rx_snap = rx_d.size();
    repeat (80) @(negedge clk);
    n_vec++;
    if (rx_d.size() != rx_snap) begin n_miss++; $display("FAIL t5_no_rx: count=%0d, required %0d", rx_d.size(), rx_snap); end
    slv_q.delete();
    slv_bit = 0;
    clear_logs();
    slv_q.push_back(8'hC3);
    tx_bytes[0] = 8'h5A;
    do_burst(1, 0, -1, 0, gb);
    n_vec++;
    if (rx_d.size() != 1) begin
      n_miss++; $display("FAIL t5_rx_count: %0d, required 1", rx_d.size());
    end else if (rx_d[0] !== 8'hC3 || rx_i[0] != 1 || rx_l[0] !== 1'b1) begin
      n_miss++; $display("FAIL t5_rx: data=%h id=%0d last=%b, required c3/1/1", rx_d[0], rx_i[0], rx_l[0]);
    end
  endtask

  task automatic test_full_length();
    int gb;
    int n_last;
    logic [7:0] exp_rx [16];
    clear_logs();
    for (int i = 0; i < 16; i++) begin
      tx_bytes[i] = 8'(i * 7 + 3);
      exp_rx[i]   = 8'(8'hF0 - i);
      slv_q.push_back(exp_rx[i]);
    end
    do_burst(0, 15, -1, 0, gb);
    n_vec++;
    if (sclk_rises != 128) begin n_miss++; $display("FAIL t6_sclk_rises: %0d, required 128", sclk_rises); end
    n_vec++;
    if (txr_cnt[0] != 16) begin n_miss++; $display("FAIL t6_tx_ready: %0d, required 16", txr_cnt[0]); end
    n_vec++;
    if (rx_d.size() != 16) begin
      n_miss++; $display("FAIL t6_rx_count: %0d, required 16", rx_d.size());
    end else begin
      n_last = 0;
      for (int i = 0; i < 16; i++) begin
        if (rx_l[i]) n_last++;
        n_vec++;
        if (rx_d[i] !== exp_rx[i]) begin
          n_miss++; $display("FAIL t6_rx%0d: %h, required %h", i, rx_d[i], exp_rx[i]);
        end
      end
      n_vec++;
      if (n_last != 1 || rx_l[15] !== 1'b1) begin
        n_miss++; $display("FAIL t6_last: count=%0d last16=%b, required 1/1", n_last, rx_l[15]);
      end
    end
  endtask

  task automatic test_cs_exclusive();
    n_vec++;
    if (cs_multi != 0) begin n_miss++; $display("FAIL cs_exclusive: %0d cycles, required 0", cs_multi); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_multi_byte();
    test_arbitration();
    test_tx_gap();
    test_reset_mid_burst();
    test_full_length();
    test_cs_exclusive();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
